// File: rtl/alu_result_stage.sv
// Gumnut ALU result stage: registers result and Z/C flags from the extension's OPA/OPB/carry.
// Arithmetic/logic ops commit in one cycle; shifts/rotates step one bit per cycle in SHIFT.
module alu_result_stage (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] op_i,
   input  logic [7:0] opa_i,
   input  logic [7:0] opb_i,
   input  logic       cin_i,
   input  logic       sub_i,
   input  logic [2:0] count_i,
   output logic [7:0] result_o,
   output logic       z_o,
   output logic       c_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [3:0] OP_ARITH = 4'h0;
   localparam logic [3:0] OP_AND   = 4'h1;
   localparam logic [3:0] OP_OR    = 4'h2;
   localparam logic [3:0] OP_XOR   = 4'h3;
   localparam logic [3:0] OP_MASK  = 4'h4;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_ROL   = 4'hA;
   localparam logic [3:0] OP_ROR   = 4'hB;

   typedef enum logic {IDLE, SHIFT} state_t;

   typedef struct packed {
      logic       c;
      logic [7:0] val;
   } step_t;

   state_t     state, state_n;
   logic [7:0] shreg, shreg_n;
   logic [2:0] cnt, cnt_n;
   logic [1:0] sop, sop_n;
   logic       commit, fin;
   logic [7:0] res_v;
   logic       c_v;
   logic [8:0] sum;
   step_t      step;

   // One-bit step; sop is op[1:0]: 0 SHL, 1 SHR, 2 ROL, 3 ROR.
   function automatic step_t shift_step(input logic [1:0] s, input logic [7:0] v);
      step_t r;
      case (s)
         2'd0:    begin r.c = v[7]; r.val = {v[6:0], 1'b0}; end
         2'd1:    begin r.c = v[0]; r.val = {1'b0, v[7:1]}; end
         2'd2:    begin r.c = v[7]; r.val = {v[6:0], v[7]}; end
         default: begin r.c = v[0]; r.val = {v[0], v[7:1]}; end
      endcase
      return r;
   endfunction

   assign sum    = {1'b0, opa_i} + {1'b0, opb_i} + {8'd0, cin_i};
   assign step   = shift_step(sop, shreg);
   assign busy_o = (state == SHIFT);

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      sop_n   = sop;
      commit  = 1'b0;
      fin     = 1'b0;
      res_v   = result_o;
      c_v     = c_o;
      case (state)
         IDLE: begin
            if (start_i) begin
               fin = 1'b1;
               case (op_i)
                  OP_ARITH: begin commit = 1'b1; res_v = sum[7:0];       c_v = sum[8] ^ sub_i; end
                  OP_AND:   begin commit = 1'b1; res_v = opa_i & opb_i;  c_v = 1'b0; end
                  OP_OR:    begin commit = 1'b1; res_v = opa_i | opb_i;  c_v = 1'b0; end
                  OP_XOR:   begin commit = 1'b1; res_v = opa_i ^ opb_i;  c_v = 1'b0; end
                  OP_MASK:  begin commit = 1'b1; res_v = opa_i & ~opb_i; c_v = 1'b0; end
                  OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                     if (count_i == 3'd0) begin
                        commit = 1'b1;
                        res_v  = opa_i;
                        c_v    = 1'b0;
                     end else begin
                        fin     = 1'b0;
                        state_n = SHIFT;
                        shreg_n = opa_i;
                        cnt_n   = count_i;
                        sop_n   = op_i[1:0];
                     end
                  end
                  default: ; // reserved: done pulse only, outputs held
               endcase
            end
         end
         SHIFT: begin
            // start_i is not looked at here, so mid-shift requests are dropped
            shreg_n = step.val;
            cnt_n   = cnt - 3'd1;
            if (cnt == 3'd1) begin
               commit  = 1'b1;
               fin     = 1'b1;
               res_v   = step.val;
               c_v     = step.c;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         shreg    <= 8'h00;
         cnt      <= 3'd0;
         sop      <= 2'd0;
         result_o <= 8'h00;
         z_o      <= 1'b0;
         c_o      <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         cnt    <= cnt_n;
         sop    <= sop_n;
         done_o <= fin;
         if (commit) begin
            result_o <= res_v;
            z_o      <= (res_v == 8'h00);
            c_o      <= c_v;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: hand-computed vectors, checked on the falling edge.
module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst_i, start_i, cin_i, sub_i;
   logic [3:0] op_i;
   logic [7:0] opa_i, opb_i;
   logic [2:0] count_i;
   logic [7:0] result_o;
   logic       z_o, c_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;

   alu_result_stage dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .opa_i(opa_i), .opb_i(opb_i), .cin_i(cin_i), .sub_i(sub_i),
      .count_i(count_i), .result_o(result_o), .z_o(z_o), .c_o(c_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting rising edge.
   task automatic go(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb, input logic [2:0] cn);
      op_i = op; opa_i = a; opb_i = b; cin_i = ci; sub_i = sb; count_i = cn;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic outs(input string tag, input logic [7:0] r, input logic z, input logic c,
                       input logic bsy, input logic dn);
      chk8({tag, ".result"}, result_o, r);
      chk1({tag, ".z"}, z_o, z);
      chk1({tag, ".c"}, c_o, c);
      chk1({tag, ".busy"}, busy_o, bsy);
      chk1({tag, ".done"}, done_o, dn);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; op_i = 4'h0; opa_i = 8'h00; opb_i = 8'h00;
      cin_i = 1'b0; sub_i = 1'b0; count_i = 3'd0;
      repeat (2) @(negedge clk);
      outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      @(negedge clk);

      // ARITH
      go(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 3'd0);
      outs("add7F", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk1("add7F.donewidth", done_o, 1'b0);
      chk8("add7F.hold", result_o, 8'h80);
      go(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 3'd0);
      outs("addFF", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      go(4'h0, 8'h05, 8'hF8, 1'b1, 1'b1, 3'd0);
      outs("sub05", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      go(4'h0, 8'h07, 8'hF8, 1'b1, 1'b1, 3'd0);
      outs("sub07", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // ROL 81 by 3 with an ignored start mid-shift
      go(4'hA, 8'h81, 8'h00, 1'b0, 1'b0, 3'd3);
      chk1("rol.busy1", busy_o, 1'b1);
      chk1("rol.done1", done_o, 1'b0);
      op_i = 4'h1; opa_i = 8'h00; opb_i = 8'h00; count_i = 3'd0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk1("rol.busy2", busy_o, 1'b1);
      chk1("rol.done2", done_o, 1'b0);
      @(negedge clk);
      chk1("rol.busy3", busy_o, 1'b1);
      chk8("rol.heldmid", result_o, 8'h00);
      @(negedge clk);
      outs("rol", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk1("rol.nodup", done_o, 1'b0);
      chk8("rol.hold", result_o, 8'h0C);

      // SHR by 1, SHL by 0
      go(4'h9, 8'h01, 8'h00, 1'b0, 1'b0, 3'd1);
      chk1("shr.busy", busy_o, 1'b1);
      @(negedge clk);
      outs("shr", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      go(4'h8, 8'hA5, 8'h00, 1'b0, 1'b0, 3'd0);
      outs("shl0", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // back-to-back: ARITH, reserved, AND each started on the prior done cycle
      go(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 3'd0);
      outs("b2b.add", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      go(4'h5, 8'h12, 8'h34, 1'b1, 1'b0, 3'd0);
      outs("b2b.rsv", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      go(4'h1, 8'hF0, 8'h0F, 1'b0, 1'b0, 3'd0);
      outs("b2b.and", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // remaining logic ops
      go(4'h2, 8'h0F, 8'h30, 1'b1, 1'b0, 3'd0);
      outs("or", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1);
      go(4'h3, 8'hA5, 8'hFF, 1'b0, 1'b0, 3'd0);
      outs("xor", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      go(4'h4, 8'hF0, 8'h3C, 1'b0, 1'b0, 3'd0);
      outs("mask", 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // reset during ROR by 7
      go(4'hB, 8'h5A, 8'h00, 1'b0, 1'b0, 3'd7);
      repeat (2) @(negedge clk);
      chk1("rst.busybefore", busy_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk);
      outs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk1("rst.nodone", done_o, 1'b0);
      end
      chk1("rst.idle", busy_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
